// File: rtl/expr_gen_pkg.sv
// Shared definitions for the expression generator: state encoding, ASCII
// constants, LFSR default/taps and the character/LFSR helper functions.
package expr_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIGIT = 2'd1,
    ST_OP    = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_ZERO   = 8'h30;
  localparam logic [7:0] ASCII_PLUS   = 8'h2B;
  localparam logic [7:0] ASCII_STAR   = 8'h2A;
  localparam logic [7:0] LFSR_DEFAULT = 8'h01;

  localparam int TAP_A = 7;
  localparam int TAP_B = 5;
  localparam int TAP_C = 4;
  localparam int TAP_D = 3;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D]};
  endfunction

  // Low nibble folded into 0..9 by a single subtraction (max nibble is 15).
  function automatic logic [7:0] digit_char(input logic [7:0] v);
    logic [3:0] n;
    if (v[3:0] >= 4'd10) begin
      n = v[3:0] - 4'd10;
    end else begin
      n = v[3:0];
    end
    return ASCII_ZERO + {4'd0, n};
  endfunction

  function automatic logic [7:0] op_char(input logic [7:0] v);
    return v[0] ? ASCII_STAR : ASCII_PLUS;
  endfunction

endpackage

// File: rtl/expr_gen_if.sv
// Request/response signals of the expression generator, bundled with
// modports for the requester (master) and the generator (slave).
interface expr_gen_if;
  logic       start;
  logic [3:0] len;
  logic [7:0] seed;
  logic       inject_err;
  logic [7:0] out;
  logic       out_valid;
  logic       busy;
  logic       done;

  modport master (
    output start, len, seed, inject_err,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, len, seed, inject_err,
    output out, out_valid, busy, done
  );
endinterface

// File: rtl/expr_gen_lfsr.sv
// 8-bit Fibonacci LFSR with synchronous load and single-step advance.
module expr_lfsr
  import expr_gen_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] load_val,
  output logic [7:0] value
);

  logic [7:0] value_r;

  // LFSR register: load has priority over advance.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      value_r <= LFSR_DEFAULT;
    end else if (load) begin
      value_r <= load_val;
    end else if (advance) begin
      value_r <= lfsr_step(value_r);
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/expr_gen.sv
// Random arithmetic-expression generator: emits D (O D)* one ASCII character
// per cycle from an LFSR, then pulses done for one cycle.
module expr_gen
  import expr_gen_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  expr_gen_if.slave  bus
);

  state_e     state_r, state_s;
  logic [3:0] cnt_r, cnt_s;
  logic       inject_r, inject_s;
  logic [7:0] out_r, out_s;
  logic       valid_r, valid_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;

  logic [7:0] seed_fix_s;
  logic [3:0] len_fix_s;
  logic [7:0] lfsr_val_s;
  logic [7:0] lfsr_load_val_s;
  logic       lfsr_load_s;
  logic       lfsr_adv_s;

  assign seed_fix_s = (bus.seed == 8'h00) ? LFSR_DEFAULT : bus.seed;
  assign len_fix_s  = (bus.len == 4'd0) ? 4'd1 : bus.len;

  // The first character uses the seed directly, so the LFSR is loaded
  // already one step ahead.
  assign lfsr_load_val_s = lfsr_step(seed_fix_s);

  expr_lfsr u_lfsr (
    .clk      (clk),
    .clr      (clr),
    .load     (lfsr_load_s),
    .advance  (lfsr_adv_s),
    .load_val (lfsr_load_val_s),
    .value    (lfsr_val_s)
  );

  // Next state and next output values; state names the character on out.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    inject_s    = inject_r;
    out_s       = 8'h00;
    valid_s     = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    lfsr_load_s = 1'b0;
    lfsr_adv_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s     = ST_DIGIT;
          cnt_s       = len_fix_s;
          inject_s    = bus.inject_err;
          valid_s     = 1'b1;
          busy_s      = 1'b1;
          lfsr_load_s = 1'b1;
          if (bus.inject_err && (len_fix_s == 4'd1)) begin
            out_s = op_char(seed_fix_s);
          end else begin
            out_s = digit_char(seed_fix_s);
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DIGIT: begin
        busy_s = 1'b1;
        if (cnt_r <= 4'd1) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
        end else begin
          state_s    = ST_OP;
          out_s      = op_char(lfsr_val_s);
          valid_s    = 1'b1;
          lfsr_adv_s = 1'b1;
        end
      end
      ST_OP: begin
        state_s    = ST_DIGIT;
        busy_s     = 1'b1;
        valid_s    = 1'b1;
        lfsr_adv_s = 1'b1;
        if (cnt_r > 4'd1) begin
          cnt_s = cnt_r - 4'd1;
        end else begin
          cnt_s = cnt_r;
        end
        // Count 2 here means the upcoming digit is the final character.
        if (inject_r && (cnt_r == 4'd2)) begin
          out_s = op_char(lfsr_val_s);
        end else begin
          out_s = digit_char(lfsr_val_s);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State, counter, latched options and registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      inject_r <= 1'b0;
      out_r    <= 8'h00;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      inject_r <= inject_s;
      out_r    <= out_s;
      valid_r  <= valid_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign bus.out       = out_r;
  assign bus.out_valid = valid_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_expr_gen.sv
// Self-checking bench for expr_gen: vector table + scoreboard queue, plus
// hand-written sequences for held start, async clear and mid-run changes.
module tb_expr_gen;

  logic clk = 1'b0;
  logic clr = 1'b1;
  expr_gen_if bus ();

  expr_gen dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  logic [7:0] exp_v;

  typedef struct {
    logic [7:0]  seed;
    logic [3:0]  len;
    logic        inj;
    logic        chg;
    int          n;
    logic [63:0] exp;
  } vec_t;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model: independent formulation of the character stream.
  function automatic void model_push(input logic [7:0] seed, input logic [3:0] len,
                                     input logic inj);
    logic [7:0] l;
    int total;
    l = (seed == 8'h00) ? 8'h01 : seed;
    total = 2 * ((len == 4'd0) ? 1 : int'(len)) - 1;
    for (int i = 0; i < total; i++) begin
      if ((i % 2 == 0) && !(inj && i == total - 1))
        exp_q.push_back(8'h30 + 8'((int'(l) & 15) % 10));
      else
        exp_q.push_back(l[0] ? 8'h2A : 8'h2B);
      l = {l[6:0], ^(l & 8'hB8)};
    end
  endfunction

  // Scoreboard monitor: pops expected characters as the DUT emits them.
  always @(negedge clk) begin
    if (!clr) begin
      if (bus.out_valid) begin
        got_q.push_back(bus.out);
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_char", 64'(bus.out), 64'h0);
        end else begin
          exp_v = exp_q.pop_front();
          check(bus.out == exp_v, "char", 64'(bus.out), 64'(exp_v));
        end
      end else begin
        check(bus.out == 8'h00, "out_idle_zero", 64'(bus.out), 64'h0);
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic cmp_stream(input string name, input logic [63:0] exp, input int n);
    check(got_q.size() == n, {name, "_len"}, 64'(got_q.size()), 64'(n));
    if (got_q.size() == n) begin
      for (int k = 0; k < n; k++)
        check(got_q[k] == exp[8*(n-1-k) +: 8], name, 64'(got_q[k]),
              64'(exp[8*(n-1-k) +: 8]));
    end
  endtask

  // One start pulse; checks latency, gap-free length, done pulse and busy drop.
  task automatic run_expr(input logic [7:0] seed, input logic [3:0] len,
                          input logic inj, input logic chg);
    int c;
    int total;
    int d0;
    total = 2 * ((len == 4'd0) ? 1 : int'(len)) - 1;
    got_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.seed = seed; bus.len = len; bus.inject_err = inj;
    model_push(seed, len, inj);
    @(negedge clk);
    bus.start = 1'b0;
    check(bus.out_valid == 1'b1 && bus.busy == 1'b1, "first_latency",
          64'({bus.out_valid, bus.busy}), 64'h3);
    c = 0;
    while (!bus.done && c < 40) begin
      @(negedge clk);
      c++;
      if (chg && c == 2) begin
        bus.seed = 8'hFF; bus.len = 4'd9; bus.inject_err = 1'b1; bus.start = 1'b1;
      end
      if (chg && c == 3) bus.start = 1'b0;
    end
    check(bus.done == 1'b1, "done_timeout", 64'(bus.done), 64'h1);
    check(c == total, "done_position", 64'(c), 64'(total));
    check(bus.out_valid == 1'b0 && bus.busy == 1'b1, "done_state",
          64'({bus.out_valid, bus.busy}), 64'h1);
    @(negedge clk);
    check(bus.busy == 1'b0 && bus.done == 1'b0, "after_done",
          64'({bus.busy, bus.done}), 64'h0);
    check(done_cnt == d0 + 1, "done_count", 64'(done_cnt - d0), 64'h1);
    check(exp_q.size() == 0, "scoreboard_empty", 64'(exp_q.size()), 64'h0);
  endtask

  vec_t vecs [9];

  initial begin
    vecs[0] = '{8'h01, 4'd3,  1'b0, 1'b0, 5, 64'h312B342B31};
    vecs[1] = '{8'h01, 4'd3,  1'b1, 1'b0, 5, 64'h312B342B2A};
    vecs[2] = '{8'h00, 4'd0,  1'b0, 1'b0, 1, 64'h31};
    vecs[3] = '{8'h0C, 4'd1,  1'b0, 1'b0, 1, 64'h32};
    vecs[4] = '{8'h01, 4'd3,  1'b0, 1'b1, 5, 64'h312B342B31};
    vecs[5] = '{8'h00, 4'd1,  1'b1, 1'b0, 1, 64'h2A};
    vecs[6] = '{8'hA5, 4'd15, 1'b0, 1'b0, 0, 64'h0};
    vecs[7] = '{8'h3C, 4'd7,  1'b1, 1'b0, 0, 64'h0};
    vecs[8] = '{8'hFF, 4'd4,  1'b0, 1'b0, 0, 64'h0};

    bus.start = 1'b0; bus.len = 4'd0; bus.seed = 8'h00; bus.inject_err = 1'b0;
    #12;
    check(bus.out == 8'h00 && !bus.out_valid && !bus.busy && !bus.done, "reset_state",
          64'({bus.out, bus.out_valid, bus.busy, bus.done}), 64'h0);
    @(negedge clk);
    clr = 1'b0;

    foreach (vecs[i]) begin
      run_expr(vecs[i].seed, vecs[i].len, vecs[i].inj, vecs[i].chg);
      if (vecs[i].n > 0) cmp_stream("vector_stream", vecs[i].exp, vecs[i].n);
    end

    // Start held high: two back-to-back expressions separated by one idle cycle.
    begin
      int d0;
      int c;
      bit prev_done;
      got_q.delete();
      d0 = done_cnt;
      prev_done = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.seed = 8'h01; bus.len = 4'd2; bus.inject_err = 1'b0;
      model_push(8'h01, 4'd2, 1'b0);
      model_push(8'h01, 4'd2, 1'b0);
      c = 0;
      while (done_cnt < d0 + 2 && c < 60) begin
        @(negedge clk);
        c++;
        if (prev_done)
          check(bus.busy == 1'b0 && bus.out_valid == 1'b0, "idle_gap",
                64'({bus.busy, bus.out_valid}), 64'h0);
        prev_done = bus.done;
      end
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check(done_cnt == d0 + 2, "held_start_dones", 64'(done_cnt - d0), 64'h2);
      check(exp_q.size() == 0, "held_start_sb", 64'(exp_q.size()), 64'h0);
      cmp_stream("held_start_stream", 64'h312B34312B34, 6);
    end

    // Asynchronous clear during the third character aborts without done.
    begin
      int d0;
      got_q.delete();
      d0 = done_cnt;
      @(negedge clk);
      bus.start = 1'b1; bus.seed = 8'h01; bus.len = 4'd3; bus.inject_err = 1'b0;
      model_push(8'h01, 4'd3, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      check(bus.out == 8'h34, "pre_clear_char", 64'(bus.out), 64'h34);
      #2 clr = 1'b1;
      #1;
      check(bus.out == 8'h00 && !bus.out_valid && !bus.busy && !bus.done, "async_clear",
            64'({bus.out, bus.out_valid, bus.busy, bus.done}), 64'h0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      clr = 1'b0;
      repeat (2) @(negedge clk);
      check(done_cnt == d0, "no_done_after_clear", 64'(done_cnt - d0), 64'h0);
      run_expr(8'h01, 4'd3, 1'b0, 1'b0);
      cmp_stream("post_clear_stream", 64'h312B342B31, 5);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
